// File: rtl/add8_err_pkg.sv
// Shared types and constants for the 8-bit adder error meter.
//   state_t   : sweep controller states
//   SUM_W     : width of an 8-bit + 8-bit sum
//   SAE_W     : sum-of-absolute-errors width (65536 * 511 fits)
//   WCE_W     : worst-case error width
//   ECNT_W    : error-count width (up to 65536)
//   LAT_MAX   : largest supported adder latency
//   abs_diff  : |x - y| for two sums
package add8_err_pkg;

  localparam int unsigned SUM_W   = 9;
  localparam int unsigned SAE_W   = 25;
  localparam int unsigned WCE_W   = 9;
  localparam int unsigned ECNT_W  = 17;
  localparam int unsigned LAT_MAX = 3;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } state_t;

  function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] x,
                                                input logic [SUM_W-1:0] y);
    return (x >= y) ? x - y : y - x;
  endfunction

endpackage

// File: rtl/add8_err_delay.sv
// Delay line carrying the exact reference sum and its valid flag so that they
// line up with the result of an adder with LAT pipeline stages.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop every in-flight valid bit on this edge
//   sum_in     : exact sum of the operands currently driven to the adder
//   valid_in   : sum_in belongs to an issued vector
//   sum_out    : sum_in delayed LAT cycles
//   valid_out  : valid_in delayed LAT cycles
// LAT = 0 is a pure pass-through.
module add8_err_delay
  import add8_err_pkg::*;
#(
  parameter int unsigned LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             valid_in,
  output logic [SUM_W-1:0] sum_out,
  output logic             valid_out
);

  generate
    if (LAT == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, flush};
      assign sum_out   = sum_in;
      assign valid_out = valid_in;
    end else begin : g_pipe
      logic [SUM_W-1:0] sum_q [LAT];
      logic [LAT-1:0]   valid_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
          for (int unsigned i = 0; i < LAT; i++) sum_q[i] <= '0;
        end else begin
          valid_q[0] <= valid_in & ~flush;
          sum_q[0]   <= sum_in;
          for (int unsigned i = 1; i < LAT; i++) begin
            valid_q[i] <= valid_q[i-1] & ~flush;
            sum_q[i]   <= sum_q[i-1];
          end
        end
      end

      assign sum_out   = sum_q[LAT-1];
      assign valid_out = valid_q[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/add8_err_meter.sv
// Exhaustive error meter for an external 8-bit adder. On start it drives all
// 65536 operand pairs (one per cycle), compares each returned sum with the
// exact sum and accumulates error statistics.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a sweep (ignored while busy; wins over abort in IDLE)
//   abort        : end a running sweep, statistics frozen, done stays low
//   dut_a, dut_b : registered operands to the adder under test
//   dut_o        : sum from the adder under test, LAT cycles after dut_a/b
//   busy         : sweep in progress
//   done         : statistics valid, held until next start or reset
//   sae          : sum of absolute errors
//   wce          : worst-case absolute error
//   ecnt         : number of vectors with a nonzero error
module add8_err_meter
  import add8_err_pkg::*;
#(
  parameter int unsigned LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [7:0]        dut_a,
  output logic [7:0]        dut_b,
  input  logic [SUM_W-1:0]  dut_o,
  output logic              busy,
  output logic              done,
  output logic [SAE_W-1:0]  sae,
  output logic [WCE_W-1:0]  wce,
  output logic [ECNT_W-1:0] ecnt
);

  localparam int unsigned LAT_EFF    = (LAT > LAT_MAX) ? LAT_MAX : LAT;
  localparam logic [1:0]  DRAIN_LAST = 2'(LAT_EFF);

  state_t           state, state_next;
  logic [15:0]      cnt;
  logic [1:0]       drain_cnt;
  logic             issue_valid;
  logic [SUM_W-1:0] exact_in;
  logic [SUM_W-1:0] exact_d;
  logic             cmp_valid;
  logic [WCE_W-1:0] err;
  logic             launch;
  logic             kill;

  assign launch = (state == IDLE) && start;
  assign kill   = (state != IDLE) && abort;
  assign busy   = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = SWEEP;
      SWEEP: begin
        if (abort)                   state_next = IDLE;
        else if (cnt == 16'hFFFF)    state_next = DRAIN;
      end
      DRAIN: begin
        if (abort)                        state_next = IDLE;
        else if (drain_cnt == DRAIN_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign exact_in = {1'b0, dut_a} + {1'b0, dut_b};

  add8_err_delay #(.LAT(LAT_EFF)) u_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (kill),
    .sum_in    (exact_in),
    .valid_in  (issue_valid),
    .sum_out   (exact_d),
    .valid_out (cmp_valid)
  );

  assign err = abs_diff(dut_o, exact_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dut_a       <= '0;
      dut_b       <= '0;
      issue_valid <= 1'b0;
      drain_cnt   <= '0;
      done        <= 1'b0;
      sae         <= '0;
      wce         <= '0;
      ecnt        <= '0;
    end else begin
      // Operands only advance on non-aborting SWEEP cycles, so they hold
      // their last issued value everywhere else.
      issue_valid <= (state == SWEEP) && !abort;
      drain_cnt   <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;

      if ((state == SWEEP) && !abort) begin
        dut_a <= cnt[7:0];
        dut_b <= cnt[15:8];
        cnt   <= cnt + 16'd1;
      end

      if ((state == DRAIN) && !abort && (drain_cnt == DRAIN_LAST))
        done <= 1'b1;

      if (launch) begin
        cnt  <= '0;
        done <= 1'b0;
        sae  <= '0;
        wce  <= '0;
        ecnt <= '0;
      end else if (cmp_valid && !kill) begin
        // The compare landing on the abort edge is dropped too, so the
        // statistics freeze exactly at the abort request.
        sae  <= sae + SAE_W'(err);
        ecnt <= ecnt + ECNT_W'(err != '0);
        if (err > wce) wce <= err;
      end
    end
  end

endmodule

// File: tb/tb_add8_err_meter.sv
// Self-checking bench for add8_err_meter. Six meters share one clock and sweep
// in parallel, each against its own behavioural adder:
//   u0 LAT0 exact, u1 LAT0 A+B+1, u2 LAT0 constant 0, u3 LAT2 exact (two regs),
//   u4 LAT1 A+B+1 (one reg; abort then restart), u5 LAT0 A+B+1 (reset mid-run,
//   then start+abort together).
// Expected statistics come from a software sweep of the same adder models and
// are queued per meter at start; the monitor pops them when done rises.
module tb_add8_err_meter;

  localparam int N = 6;

  typedef struct {
    longint start_cyc;
    longint lat;
    longint sae;
    longint wce;
    longint ecnt;
  } exp_t;

  logic        clk = 1'b0;
  longint      cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        rst_n  [N];
  logic        start  [N];
  logic        abort  [N];
  logic [7:0]  a_v    [N];
  logic [7:0]  b_v    [N];
  logic        busy_v [N];
  logic        done_v [N];
  logic [24:0] sae_v  [N];
  logic [8:0]  wce_v  [N];
  logic [16:0] ecnt_v [N];
  logic [8:0]  o0, o1, o2, o3, o4, o5;
  logic [8:0]  r3a, r3b, r4;

  exp_t        sb [N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adders under test
  assign o0 = {1'b0, a_v[0]} + {1'b0, b_v[0]};
  assign o1 = {1'b0, a_v[1]} + {1'b0, b_v[1]} + 9'd1;
  assign o2 = '0;
  always @(posedge clk) begin
    r3a <= {1'b0, a_v[3]} + {1'b0, b_v[3]};
    r3b <= r3a;
    r4  <= {1'b0, a_v[4]} + {1'b0, b_v[4]} + 9'd1;
  end
  assign o3 = r3b;
  assign o4 = r4;
  assign o5 = {1'b0, a_v[5]} + {1'b0, b_v[5]} + 9'd1;

  add8_err_meter #(.LAT(0)) u0 (.clk(clk), .rst_n(rst_n[0]), .start(start[0]), .abort(abort[0]),
    .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_o(o0), .busy(busy_v[0]), .done(done_v[0]),
    .sae(sae_v[0]), .wce(wce_v[0]), .ecnt(ecnt_v[0]));
  add8_err_meter #(.LAT(0)) u1 (.clk(clk), .rst_n(rst_n[1]), .start(start[1]), .abort(abort[1]),
    .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_o(o1), .busy(busy_v[1]), .done(done_v[1]),
    .sae(sae_v[1]), .wce(wce_v[1]), .ecnt(ecnt_v[1]));
  add8_err_meter #(.LAT(0)) u2 (.clk(clk), .rst_n(rst_n[2]), .start(start[2]), .abort(abort[2]),
    .dut_a(a_v[2]), .dut_b(b_v[2]), .dut_o(o2), .busy(busy_v[2]), .done(done_v[2]),
    .sae(sae_v[2]), .wce(wce_v[2]), .ecnt(ecnt_v[2]));
  add8_err_meter #(.LAT(2)) u3 (.clk(clk), .rst_n(rst_n[3]), .start(start[3]), .abort(abort[3]),
    .dut_a(a_v[3]), .dut_b(b_v[3]), .dut_o(o3), .busy(busy_v[3]), .done(done_v[3]),
    .sae(sae_v[3]), .wce(wce_v[3]), .ecnt(ecnt_v[3]));
  add8_err_meter #(.LAT(1)) u4 (.clk(clk), .rst_n(rst_n[4]), .start(start[4]), .abort(abort[4]),
    .dut_a(a_v[4]), .dut_b(b_v[4]), .dut_o(o4), .busy(busy_v[4]), .done(done_v[4]),
    .sae(sae_v[4]), .wce(wce_v[4]), .ecnt(ecnt_v[4]));
  add8_err_meter #(.LAT(0)) u5 (.clk(clk), .rst_n(rst_n[5]), .start(start[5]), .abort(abort[5]),
    .dut_a(a_v[5]), .dut_b(b_v[5]), .dut_o(o5), .busy(busy_v[5]), .done(done_v[5]),
    .sae(sae_v[5]), .wce(wce_v[5]), .ecnt(ecnt_v[5]));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: exact, 1: A+B+1, 2: constant 0
  function automatic exp_t sweep_expect(input int mode, input longint lat, input longint s);
    exp_t e;
    e.start_cyc = s;
    e.lat  = lat;
    e.sae  = 0;
    e.wce  = 0;
    e.ecnt = 0;
    for (int v = 0; v < 65536; v++) begin
      int a, b, exact, got, err;
      a = v % 256;
      b = v / 256;
      exact = a + b;
      got = (mode == 0) ? exact : (mode == 1) ? exact + 1 : 0;
      err = (got > exact) ? got - exact : exact - got;
      e.sae += err;
      if (err > e.wce) e.wce = err;
      if (err != 0) e.ecnt++;
    end
    return e;
  endfunction

  task automatic goto_cyc(input longint t);
    while (cyc < t) @(negedge clk);
  endtask

  // Scoreboard consumer
  initial begin
    logic done_q [N];
    exp_t e;
    for (int i = 0; i < N; i++) done_q[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (done_v[i] && !done_q[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("u%0d_spurious_done", i), done_v[i], 0);
          end else begin
            e = sb[i].pop_front();
            check($sformatf("u%0d_sae", i),    sae_v[i],  e.sae);
            check($sformatf("u%0d_wce", i),    wce_v[i],  e.wce);
            check($sformatf("u%0d_ecnt", i),   ecnt_v[i], e.ecnt);
            check($sformatf("u%0d_cycles", i), cyc - e.start_cyc, 65537 + e.lat);
          end
        end
        done_q[i] = done_v[i];
      end
    end
  end

  initial begin
    longint s;
    bit     empty;
    exp_t   e2;

    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      abort[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_sae",  sae_v[0],  0);
    check("rst_wce",  wce_v[0],  0);
    check("rst_ecnt", ecnt_v[0], 0);
    check("rst_a",    a_v[3],    0);
    check("rst_b",    b_v[3],    0);
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    repeat (2) @(negedge clk);

    // Launch all meters on the same edge
    s = cyc + 1;
    for (int i = 0; i < N; i++) start[i] = 1'b1;
    sb[0].push_back(sweep_expect(0, 0, s));
    sb[1].push_back(sweep_expect(1, 0, s));
    e2 = sweep_expect(2, 0, s);
    sb[2].push_back(e2);
    sb[3].push_back(sweep_expect(0, 2, s));
    @(negedge clk);
    for (int i = 0; i < N; i++) start[i] = 1'b0;
    check("start_busy0", busy_v[0], 1);
    check("start_done0", done_v[0], 0);
    check("start_busy3", busy_v[3], 1);

    goto_cyc(s + 258);
    check("vec257_a", a_v[0], 1);
    check("vec257_b", b_v[0], 1);

    // Asynchronous reset mid-sweep on u5
    goto_cyc(s + 299);
    check("u5_mid_sae", sae_v[5], 298);
    rst_n[5] = 1'b0;
    #1;
    check("u5_rst_busy", busy_v[5], 0);
    check("u5_rst_done", done_v[5], 0);
    check("u5_rst_sae",  sae_v[5],  0);
    check("u5_rst_wce",  wce_v[5],  0);
    check("u5_rst_ecnt", ecnt_v[5], 0);
    check("u5_rst_a",    a_v[5],    0);
    check("u5_rst_b",    b_v[5],    0);
    @(negedge clk);
    rst_n[5] = 1'b1;
    goto_cyc(s + 305);
    check("u5_idle_busy", busy_v[5], 0);
    check("u5_idle_done", done_v[5], 0);

    // Start and abort together in IDLE: start wins
    goto_cyc(s + 309);
    start[5] = 1'b1;
    abort[5] = 1'b1;
    sb[5].push_back(sweep_expect(1, 0, cyc + 1));
    @(negedge clk);
    start[5] = 1'b0;
    abort[5] = 1'b0;
    check("u5_startwins_busy", busy_v[5], 1);

    // Second start while busy must not disturb u1
    goto_cyc(s + 499);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    check("u1_restart_busy", busy_v[1], 1);
    check("u1_restart_a",    a_v[1],    243);

    // Abort u4 at its sweep cycle 1000
    goto_cyc(s + 999);
    abort[4] = 1'b1;
    @(negedge clk);
    abort[4] = 1'b0;
    check("u4_abort_busy", busy_v[4], 0);
    check("u4_abort_done", done_v[4], 0);
    check("u4_abort_sae",  sae_v[4],  997);
    check("u4_abort_ecnt", ecnt_v[4], 997);
    check("u4_abort_wce",  wce_v[4],  1);
    check("u4_abort_a",    a_v[4],    230);
    check("u4_abort_b",    b_v[4],    3);
    goto_cyc(s + 1004);
    check("u4_frozen_sae", sae_v[4], 997);
    check("u4_frozen_a",   a_v[4],   230);
    check("u4_frozen_busy", busy_v[4], 0);

    goto_cyc(s + 1009);
    start[4] = 1'b1;
    sb[4].push_back(sweep_expect(1, 1, cyc + 1));
    @(negedge clk);
    start[4] = 1'b0;
    check("u4_restart_busy", busy_v[4], 1);
    check("u4_restart_sae",  sae_v[4],  0);

    // Wait for every queued result, bounded
    for (int n = 0; n < 70000; n++) begin
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (sb[i].size() != 0) empty = 1'b0;
      if (empty) break;
      @(negedge clk);
    end
    for (int i = 0; i < N; i++)
      if (sb[i].size() != 0) check($sformatf("u%0d_timeout_pending", i), sb[i].size(), 0);

    // done is held, then cleared by a new start
    repeat (3) @(negedge clk);
    check("u0_done_held", done_v[0], 1);
    check("u0_busy_low",  busy_v[0], 0);
    check("u2_sae_held",  sae_v[2],  e2.sae);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    check("u2_rerun_done", done_v[2], 0);
    check("u2_rerun_busy", busy_v[2], 1);
    check("u2_rerun_sae",  sae_v[2],  0);
    check("u2_rerun_wce",  wce_v[2],  0);
    check("u2_rerun_ecnt", ecnt_v[2], 0);
    abort[2] = 1'b1;
    @(negedge clk);
    abort[2] = 1'b0;
    check("u2_abort_busy", busy_v[2], 0);
    check("u2_abort_done", done_v[2], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
